// File: rtl/mdio_slave_if.sv
// MDIO pad pins and local register-access port shared by the responder and its environment.
interface mdio_slave_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  logic              mdc;
  logic              mdio_i;
  logic              mdio_o;
  logic              mdio_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              frame_err;

  modport slave (
    input  mdc, mdio_i, reg_rdata,
    output mdio_o, mdio_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_err
  );

  modport master (
    output mdc, mdio_i, reg_rdata,
    input  mdio_o, mdio_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_err
  );
endinterface

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk, decodes frames for PHY_ADDR
// and bridges them to a single-cycle register strobe port.
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic         clk,
  input logic         rst_n,
  mdio_slave_if.slave bus
);
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned BIT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [BIT_W-1:0] LAST_OP   = BIT_W'(1);
  localparam logic [BIT_W-1:0] LAST_ADDR = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_PRE   = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA1   = 3'd5;
  localparam logic [2:0] S_TA2   = 3'd6;
  localparam logic [2:0] S_DATA  = 3'd7;

  logic [SYNC_STAGES-1:0] r_mdc_sync, r_mdio_sync;
  logic                   r_mdc_prev;
  logic                   w_mdc, w_mdio, w_bit;

  logic [2:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_pre_cnt, w_pre_cnt_nxt;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic              r_skip, w_skip_nxt;
  logic              r_is_read, w_is_read_nxt;
  logic              r_bad_ta, w_bad_ta_nxt;
  logic              r_ta1, w_ta1_nxt;
  logic              r_re_d;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shift_in;
  logic              r_mdio_o, w_mdio_o_nxt;
  logic              r_mdio_oe, w_mdio_oe_nxt;
  logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_nxt;
  logic [DATA_W-1:0] r_reg_wdata, w_reg_wdata_nxt;
  logic              r_reg_we, w_reg_we_nxt;
  logic              r_reg_re, w_reg_re_nxt;
  logic              r_frame_err, w_frame_err_nxt;

  // Synchronisers reset high so an idle-high MDC never fakes a rising edge at reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdc_sync  <= '1;
      r_mdio_sync <= '1;
      r_mdc_prev  <= 1'b1;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], bus.mdc};
      r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], bus.mdio_i};
      r_mdc_prev  <= w_mdc;
    end
  end

  assign w_mdc      = r_mdc_sync[SYNC_STAGES-1];
  assign w_mdio     = r_mdio_sync[SYNC_STAGES-1];
  assign w_bit      = w_mdc & ~r_mdc_prev;
  assign w_shift_in = {r_shift[DATA_W-2:0], w_mdio};

  // Frame decoder: every field advances on an MDC bit event; skip frames still walk all fields
  always_comb begin
    w_state_nxt     = r_state;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_skip_nxt      = r_skip;
    w_is_read_nxt   = r_is_read;
    w_bad_ta_nxt    = r_bad_ta;
    w_ta1_nxt       = r_ta1;
    w_shift_nxt     = r_shift;
    w_mdio_o_nxt    = r_mdio_o;
    w_mdio_oe_nxt   = r_mdio_oe;
    w_reg_addr_nxt  = r_reg_addr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_reg_we_nxt    = 1'b0;
    w_reg_re_nxt    = 1'b0;
    w_frame_err_nxt = 1'b0;

    if (r_re_d) w_shift_nxt = bus.reg_rdata;

    if (w_bit) begin
      unique case (r_state)
        S_PRE: begin
          if (w_mdio) begin
            if (r_pre_cnt != CNT_MAX) w_pre_cnt_nxt = r_pre_cnt + 1'b1;
          end else begin
            w_pre_cnt_nxt = '0;
            if (32'(r_pre_cnt) >= PREAMBLE_MIN) w_state_nxt = S_ST;
          end
        end
        S_ST: begin
          w_bit_cnt_nxt = '0;
          w_skip_nxt    = 1'b0;
          w_is_read_nxt = 1'b0;
          w_bad_ta_nxt  = 1'b0;
          w_state_nxt   = w_mdio ? S_OP : S_PRE;
        end
        S_OP: begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_OP) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_PHYAD;
            w_is_read_nxt = r_shift[0] & ~w_mdio;
            if (r_shift[0] == w_mdio) w_skip_nxt = 1'b1;
          end
        end
        S_PHYAD: begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_ADDR) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_REGAD;
            if (w_shift_in[ADDR_W-1:0] != PHY_ADDR) w_skip_nxt = 1'b1;
          end
        end
        S_REGAD: begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_ADDR) begin
            w_bit_cnt_nxt  = '0;
            w_state_nxt    = S_TA1;
            w_reg_addr_nxt = w_shift_in[ADDR_W-1:0];
            w_reg_re_nxt   = r_is_read & ~r_skip;
          end
        end
        S_TA1: begin
          w_ta1_nxt   = w_mdio;
          w_state_nxt = S_TA2;
          if (r_is_read && !r_skip) begin
            w_mdio_oe_nxt = 1'b1;
            w_mdio_o_nxt  = 1'b0;
          end
        end
        S_TA2: begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
          if (r_is_read) begin
            if (!r_skip) w_mdio_o_nxt = r_shift[DATA_W-1];
          end else if ({r_ta1, w_mdio} != 2'b10) begin
            w_bad_ta_nxt = 1'b1;
          end
        end
        S_DATA: begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_is_read) begin
            w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
            if (!r_skip) w_mdio_o_nxt = r_shift[DATA_W-2];
          end else begin
            w_shift_nxt = w_shift_in;
          end
          if (r_bit_cnt == LAST_DATA) begin
            w_bit_cnt_nxt = '0;
            w_pre_cnt_nxt = '0;
            w_state_nxt   = S_PRE;
            if (r_is_read) begin
              w_mdio_oe_nxt = 1'b0;
              w_mdio_o_nxt  = 1'b1;
            end else if (!r_skip) begin
              if (r_bad_ta) begin
                w_frame_err_nxt = 1'b1;
              end else begin
                w_reg_wdata_nxt = w_shift_in;
                w_reg_we_nxt    = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PRE;
      r_pre_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_skip      <= 1'b0;
      r_is_read   <= 1'b0;
      r_bad_ta    <= 1'b0;
      r_ta1       <= 1'b0;
      r_re_d      <= 1'b0;
      r_shift     <= '0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_skip      <= w_skip_nxt;
      r_is_read   <= w_is_read_nxt;
      r_bad_ta    <= w_bad_ta_nxt;
      r_ta1       <= w_ta1_nxt;
      r_re_d      <= r_reg_re;
      r_shift     <= w_shift_nxt;
      r_mdio_o    <= w_mdio_o_nxt;
      r_mdio_oe   <= w_mdio_oe_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_reg_re    <= w_reg_re_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign bus.mdio_o    = r_mdio_o;
  assign bus.mdio_oe   = r_mdio_oe;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wdata = r_reg_wdata;
  assign bus.reg_we    = r_reg_we;
  assign bus.reg_re    = r_reg_re;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_mdio_slave.sv
// Bench for mdio_slave: a station drives MDIO frames bit by bit and a frame-level model
// predicts strobes and read-back bits; an emulated register file answers reg_re.
module tb_mdio_slave;
  localparam logic [4:0] PHY  = 5'd0;
  localparam int         PMIN = 32;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_WE   = 2'd1;
  localparam logic [1:0] K_RE   = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } ev_t;

  logic clk;
  logic rst_n;
  logic st_mdc, st_oe, st_drv;
  logic mem_clr;

  mdio_slave_if bus ();

  mdio_slave #(
    .PHY_ADDR    (PHY),
    .PREAMBLE_MIN(PMIN),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad with pull-up: DUT wins when enabled, else the station, else idle high
  assign bus.mdc    = st_mdc;
  assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : (st_oe ? st_drv : 1'b1);

  function automatic logic [15:0] init_val(input logic [4:0] a);
    return ({11'd0, a} * 16'h1357) ^ 16'hA5A5;
  endfunction

  // Emulated register file: read data valid only in the cycle after reg_re
  logic [15:0] phy_mem [32];
  logic [31:0] phy_wr;
  always @(posedge clk) begin
    if (mem_clr) phy_wr <= '0;
    else if (bus.reg_we) begin
      phy_mem[bus.reg_addr] <= bus.reg_wdata;
      phy_wr[bus.reg_addr]  <= 1'b1;
    end
    if (bus.reg_re)
      bus.reg_rdata <= phy_wr[bus.reg_addr] ? phy_mem[bus.reg_addr] : init_val(bus.reg_addr);
    else
      bus.reg_rdata <= 16'($urandom);
  end

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  oe_cnt;
  int  both_cnt;
  initial begin
    oe_cnt   = 0;
    both_cnt = 0;
  end
  always @(negedge clk) begin
    if (bus.reg_we)    obs_q.push_back({K_WE, bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re)    obs_q.push_back({K_RE, bus.reg_addr, 16'h0000});
    if (bus.frame_err) obs_q.push_back({K_ERR, 5'd0, 16'h0000});
    if (bus.reg_we && bus.reg_re) both_cnt++;
    if (bus.mdio_oe) oe_cnt++;
  end

  logic [15:0] model_mem [32];
  int m_ones;
  int checks;
  int errors;

  task automatic send_bit(input logic b, input logic drive, output logic line);
    st_mdc = 1'b0;
    st_oe  = drive;
    st_drv = b;
    #100;
    line   = bus.mdio_i;
    st_mdc = 1'b1;
    #100;
    if (line) m_ones++;
    else m_ones = 0;
  endtask

  // Sends one frame and predicts its effect from frame-level rules
  task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] regad,
                            input logic [1:0] ta, input logic [15:0] data, input int n_data,
                            output logic [1:0] kind, output logic [16:0] rd_bits);
    logic line;
    logic rd;
    logic acc;
    rd_bits = '1;
    rd = (op == 2'b10);
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b1, line);
    acc = (m_ones >= PMIN) && (st == 2'b01);
    send_bit(st[1], 1'b1, line);
    send_bit(st[0], 1'b1, line);
    send_bit(op[1], 1'b1, line);
    send_bit(op[0], 1'b1, line);
    for (int i = 4; i >= 0; i--) send_bit(phy[i], 1'b1, line);
    for (int i = 4; i >= 0; i--) send_bit(regad[i], 1'b1, line);
    if (rd) begin
      send_bit(1'b1, 1'b0, line);
      send_bit(1'b1, 1'b0, line);
      rd_bits[16] = line;
    end else begin
      send_bit(ta[1], 1'b1, line);
      send_bit(ta[0], 1'b1, line);
    end
    for (int i = 0; i < n_data; i++) begin
      send_bit(data[15-i], !rd, line);
      if (rd) rd_bits[15-i] = line;
    end
    kind = K_NONE;
    if (acc && phy == PHY && (op == 2'b01 || op == 2'b10))
      kind = rd ? K_RE : ((ta == 2'b10) ? K_WE : K_ERR);
    if (kind == K_WE) begin
      exp_q.push_back({K_WE, regad, data});
      model_mem[regad] = data;
    end else if (kind == K_RE) exp_q.push_back({K_RE, regad, 16'h0000});
    else if (kind == K_ERR) exp_q.push_back({K_ERR, 5'd0, 16'h0000});
    if (acc) m_ones = 0;
    st_oe  = 1'b1;
    st_drv = 1'b1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    st_mdc = 1'b1;
    st_oe  = 1'b1;
    st_drv = 1'b1;
    #40;
    checks++; if (bus.mdio_o !== 1'b1) begin errors++; $display("FAIL rst_mdio_o got %b exp 1", bus.mdio_o); end
    checks++; if (bus.mdio_oe !== 1'b0) begin errors++; $display("FAIL rst_mdio_oe got %b exp 0", bus.mdio_oe); end
    checks++; if (bus.reg_addr !== 5'd0) begin errors++; $display("FAIL rst_reg_addr got %h exp 0", bus.reg_addr); end
    checks++; if (bus.reg_wdata !== 16'h0) begin errors++; $display("FAIL rst_reg_wdata got %h exp 0", bus.reg_wdata); end
    checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL rst_reg_we got %b exp 0", bus.reg_we); end
    checks++; if (bus.reg_re !== 1'b0) begin errors++; $display("FAIL rst_reg_re got %b exp 0", bus.reg_re); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b exp 0", bus.frame_err); end
    rst_n = 1'b1;
    #40;
    checks++; if (bus.mdio_oe !== 1'b0 || bus.reg_we !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle got oe=%b we=%b exp 0 0", bus.mdio_oe, bus.reg_we);
    end
  endtask

  task automatic test_write_single;
    int ob = obs_q.size(); int eb = exp_q.size(); int oe0 = oe_cnt;
    logic [1:0] k; logic [16:0] rb;
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd20, 2'b10, 16'h0CE6, 16, k, rb);
    #200;
    checks++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin
      errors++; $display("FAIL write_single_count got %0d exp %0d", obs_q.size() - ob, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++; if (obs_q[ob+i] !== exp_q[eb+i]) begin errors++; $display("FAIL write_single_ev got %h exp %h", obs_q[ob+i], exp_q[eb+i]); end
    end
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL write_single_oe got %0d cycles exp 0", oe_cnt - oe0); end
  endtask

  task automatic test_back_to_back;
    int ob = obs_q.size(); int eb = exp_q.size(); int oe0 = oe_cnt;
    logic [1:0] k; logic [16:0] rb;
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd0, 2'b10, 16'h9140, 16, k, rb);
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd20, 2'b10, 16'h0CE6, 16, k, rb);
    for (int n = 0; n < 3; n++)
      send_frame(int'($urandom_range(32, 40)), 2'b01, 2'b01, 5'd0, 5'($urandom), 2'b10, 16'($urandom), 16, k, rb);
    #200;
    checks++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin
      errors++; $display("FAIL b2b_count got %0d exp %0d", obs_q.size() - ob, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++; if (obs_q[ob+i] !== exp_q[eb+i]) begin errors++; $display("FAIL b2b_ev got %h exp %h", obs_q[ob+i], exp_q[eb+i]); end
    end
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL b2b_oe got %0d cycles exp 0", oe_cnt - oe0); end
  endtask

  task automatic test_read;
    int ob = obs_q.size(); int eb = exp_q.size(); int oe0;
    logic [1:0] k; logic [16:0] rb; logic [4:0] ra;
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd2, 2'b10, 16'h0141, 16, k, rb);
    oe0 = oe_cnt;
    send_frame(32, 2'b01, 2'b10, 5'd0, 5'd2, 2'b00, 16'h0000, 16, k, rb);
    checks++; if (rb !== {1'b0, model_mem[2]}) begin errors++; $display("FAIL read_reg2_bits got %h exp %h", rb, {1'b0, model_mem[2]}); end
    checks++; if (oe_cnt == oe0) begin errors++; $display("FAIL read_oe got %0d cycles exp nonzero", oe_cnt - oe0); end
    checks++; if (bus.mdio_oe !== 1'b0 || bus.mdio_o !== 1'b1) begin
      errors++; $display("FAIL read_release got oe=%b o=%b exp 0 1", bus.mdio_oe, bus.mdio_o);
    end
    for (int n = 0; n < 3; n++) begin
      ra = 5'($urandom);
      send_frame(int'($urandom_range(32, 36)), 2'b01, 2'b10, 5'd0, ra, 2'b00, 16'h0000, 16, k, rb);
      checks++; if (rb !== {1'b0, model_mem[ra]}) begin errors++; $display("FAIL read_rand_bits got %h exp %h", rb, {1'b0, model_mem[ra]}); end
    end
    #200;
    checks++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin
      errors++; $display("FAIL read_count got %0d exp %0d", obs_q.size() - ob, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++; if (obs_q[ob+i] !== exp_q[eb+i]) begin errors++; $display("FAIL read_ev got %h exp %h", obs_q[ob+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_foreign;
    int ob = obs_q.size(); int eb = exp_q.size(); int oe0 = oe_cnt;
    logic [1:0] k; logic [16:0] rb;
    send_frame(32, 2'b01, 2'b10, 5'd5, 5'd2, 2'b00, 16'h0000, 16, k, rb);
    send_frame(32, 2'b01, 2'b01, 5'd5, 5'd3, 2'b10, 16'h5A5A, 16, k, rb);
    send_frame(32, 2'b01, 2'b00, 5'd0, 5'd4, 2'b10, 16'h1111, 16, k, rb);
    send_frame(32, 2'b01, 2'b11, 5'd0, 5'd4, 2'b10, 16'h2222, 16, k, rb);
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL foreign_oe got %0d cycles exp 0", oe_cnt - oe0); end
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd3, 2'b10, 16'hC0DE, 16, k, rb);
    #200;
    checks++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin
      errors++; $display("FAIL foreign_count got %0d exp %0d", obs_q.size() - ob, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++; if (obs_q[ob+i] !== exp_q[eb+i]) begin errors++; $display("FAIL foreign_ev got %h exp %h", obs_q[ob+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_preamble_ta;
    int ob = obs_q.size(); int eb = exp_q.size();
    logic [1:0] k; logic [16:0] rb;
    send_frame(16, 2'b01, 2'b01, 5'd0, 5'd9, 2'b10, 16'h1234, 16, k, rb);
    checks++; if (k !== K_NONE) begin errors++; $display("FAIL short_pre_model got %0d exp %0d", k, K_NONE); end
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd4, 2'b11, 16'h4321, 16, k, rb);
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd5, 2'b00, 16'h8765, 16, k, rb);
    #200;
    checks++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin
      errors++; $display("FAIL pre_ta_count got %0d exp %0d", obs_q.size() - ob, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++; if (obs_q[ob+i] !== exp_q[eb+i]) begin errors++; $display("FAIL pre_ta_ev got %h exp %h", obs_q[ob+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_random;
    int ob = obs_q.size(); int eb = exp_q.size();
    logic [1:0] k, op, ta; logic [16:0] rb; logic [4:0] ra, pa;
    for (int n = 0; n < 12; n++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      pa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : PHY;
      ta = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
      ra = 5'($urandom);
      send_frame(int'($urandom_range(PMIN - 4, PMIN + 8)), 2'b01, op, pa, ra, ta, 16'($urandom), 16, k, rb);
      if (k == K_RE) begin
        checks++; if (rb !== {1'b0, model_mem[ra]}) begin errors++; $display("FAIL rand_read_bits got %h exp %h", rb, {1'b0, model_mem[ra]}); end
      end
    end
    #200;
    checks++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", obs_q.size() - ob, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++; if (obs_q[ob+i] !== exp_q[eb+i]) begin errors++; $display("FAIL rand_ev got %h exp %h", obs_q[ob+i], exp_q[eb+i]); end
    end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL we_re_overlap got %0d exp 0", both_cnt); end
  endtask

  task automatic test_reset_mid;
    int ob = obs_q.size(); int eb = exp_q.size();
    logic [1:0] k; logic [16:0] rb;
    send_frame(32, 2'b01, 2'b10, 5'd0, 5'd3, 2'b00, 16'h0000, 5, k, rb);
    checks++; if (bus.mdio_oe !== 1'b1) begin errors++; $display("FAIL mid_read_oe got %b exp 1", bus.mdio_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mdio_oe !== 1'b0) begin errors++; $display("FAIL async_rst_oe got %b exp 0", bus.mdio_oe); end
    #9;
    rst_n  = 1'b1;
    m_ones = 0;
    #20;
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd7, 2'b10, 16'hBEEF, 16, k, rb);
    send_frame(32, 2'b01, 2'b10, 5'd0, 5'd7, 2'b00, 16'h0000, 16, k, rb);
    checks++; if (rb !== {1'b0, model_mem[7]}) begin errors++; $display("FAIL post_rst_read got %h exp %h", rb, {1'b0, model_mem[7]}); end
    #200;
    checks++;
    if (obs_q.size() - ob != exp_q.size() - eb) begin
      errors++; $display("FAIL rst_mid_count got %0d exp %0d", obs_q.size() - ob, exp_q.size() - eb);
    end else for (int i = 0; i < exp_q.size() - eb; i++) begin
      checks++; if (obs_q[ob+i] !== exp_q[eb+i]) begin errors++; $display("FAIL rst_mid_ev got %h exp %h", obs_q[ob+i], exp_q[eb+i]); end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_ones  = 0;
    mem_clr = 1'b1;
    for (int a = 0; a < 32; a++) model_mem[a] = init_val(5'(a));
    test_reset;
    mem_clr = 1'b0;
    test_write_single;
    test_back_to_back;
    test_read;
    test_foreign;
    test_preamble_ta;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
